// File: rtl/tff_pkg.sv
// Shared mode encoding for the T flip-flop based up/down/load counter.
package tff_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_HOLD = 2'b00;
  localparam mode_t MODE_UP   = 2'b01;
  localparam mode_t MODE_DOWN = 2'b10;
  localparam mode_t MODE_LOAD = 2'b11;

endpackage

// File: rtl/tff_cell.sv
// Single-bit T flip-flop with asynchronous active-high reset to RESET_BIT.
module tff_cell #(
  parameter logic RESET_BIT = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic t,
  output logic q,
  output logic qb
);

  logic r_q;

  // Toggle state on a rising edge whenever t is high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q <= RESET_BIT;
    end else if (t) begin
      r_q <= ~r_q;
    end
  end

  assign q  = r_q;
  assign qb = ~r_q;

endmodule

// File: rtl/tff_updown_counter.sv
// WIDTH-bit modulo up/down/load counter built from a row of T flip-flop cells.
module tff_updown_counter
  import tff_pkg::*;
#(
  parameter int unsigned     WIDTH     = 4,
  parameter longint unsigned MODULUS   = 16,
  parameter longint unsigned RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  mode_t            mode,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             tc,
  output logic             wrap,
  output logic             load_err
);

  // Reject parameter sets that cannot be built.
  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("tff_updown_counter: WIDTH must be 1..32");
  end
  if (MODULUS < 2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_modulus
    $error("tff_updown_counter: MODULUS must be 2..2**WIDTH");
  end
  if (RESET_VAL >= MODULUS) begin : g_bad_reset
    $error("tff_updown_counter: RESET_VAL must be below MODULUS");
  end

  // MODULUS itself may be 2**WIDTH, so range checks on d use one extra bit.
  localparam logic [WIDTH:0]   ModExt   = (WIDTH + 1)'(MODULUS);
  localparam logic [WIDTH-1:0] MaxVal   = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ResetVec = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] One      = WIDTH'(1);

  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_qb;
  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_t;
  logic [WIDTH:0]   w_d_ext;
  logic             w_d_oor;
  logic             w_tc;
  logic             w_load_err;
  logic             r_wrap;
  logic             r_load_err;

  // Select the requested next count; increments and decrements only happen away from the
  // wrap boundary, so they never overflow WIDTH bits.
  always_comb begin
    w_d_ext = {1'b0, d};
    w_d_oor = (w_d_ext >= ModExt);
    w_next  = w_q;
    if (en) begin
      case (mode)
        MODE_UP:   w_next = (w_q == MaxVal) ? '0 : w_q + One;
        MODE_DOWN: w_next = (w_q == '0) ? MaxVal : w_q - One;
        MODE_LOAD: w_next = w_d_oor ? MaxVal : d;
        default:   w_next = w_q;
      endcase
    end
  end

  // Terminal count and out-of-range load detection for the current inputs.
  always_comb begin
    w_tc       = en & (((mode == MODE_UP) & (w_q == MaxVal)) |
                       ((mode == MODE_DOWN) & (w_q == '0)));
    w_load_err = en & (mode == MODE_LOAD) & w_d_oor;
  end

  assign w_t = w_q ^ w_next;

  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_cell
    tff_cell #(
      .RESET_BIT(ResetVec[i])
    ) u_cell (
      .clk  (clk),
      .reset(reset),
      .t    (w_t[i]),
      .q    (w_q[i]),
      .qb   (w_qb[i])
    );
  end

  // One-cycle wrap and load-error pulses, aligned with the new count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wrap     <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_wrap     <= w_tc;
      r_load_err <= w_load_err;
    end
  end

  assign q        = w_q;
  assign qb       = w_qb;
  assign tc       = w_tc;
  assign wrap     = r_wrap;
  assign load_err = r_load_err;

endmodule

// File: tb/tb_tff_updown_counter.sv
// Self-checking bench: MODULUS=10 counter (vector table + reset sequences) and full-range 3-bit.
module tb_tff_updown_counter;
  import tff_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: WIDTH=4, MODULUS=10, RESET_VAL=3
  logic       rst_a;
  logic       en_a;
  mode_t      mode_a;
  logic [3:0] d_a;
  logic [3:0] q_a;
  logic [3:0] qb_a;
  logic       tc_a;
  logic       wrap_a;
  logic       lerr_a;

  // Instance B: WIDTH=3, MODULUS=8, RESET_VAL=0
  logic       rst_b;
  logic       en_b;
  mode_t      mode_b;
  logic [2:0] d_b;
  logic [2:0] q_b;
  logic [2:0] qb_b;
  logic       tc_b;
  logic       wrap_b;
  logic       lerr_b;

  tff_updown_counter #(
    .WIDTH    (4),
    .MODULUS  (10),
    .RESET_VAL(3)
  ) dut_a (
    .clk     (clk),
    .reset   (rst_a),
    .en      (en_a),
    .mode    (mode_a),
    .d       (d_a),
    .q       (q_a),
    .qb      (qb_a),
    .tc      (tc_a),
    .wrap    (wrap_a),
    .load_err(lerr_a)
  );

  tff_updown_counter #(
    .WIDTH    (3),
    .MODULUS  (8),
    .RESET_VAL(0)
  ) dut_b (
    .clk     (clk),
    .reset   (rst_b),
    .en      (en_b),
    .mode    (mode_b),
    .d       (d_b),
    .q       (q_b),
    .qb      (qb_b),
    .tc      (tc_b),
    .wrap    (wrap_b),
    .load_err(lerr_b)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       en;
    mode_t      mode;
    logic [3:0] d;
    logic       tc;
    logic [3:0] q;
    logic       wrap;
    logic       lerr;
  } vec_t;

  typedef struct {
    logic       sel;
    logic [3:0] q;
    logic       wrap;
    logic       lerr;
    string      name;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic addv(input logic en, input mode_t mode, input logic [3:0] d, input logic tc,
                      input logic [3:0] q, input logic wrap, input logic lerr);
    vec_t v;
    v.en = en; v.mode = mode; v.d = d; v.tc = tc; v.q = q; v.wrap = wrap; v.lerr = lerr;
    vecs.push_back(v);
  endtask

  // Pop the oldest expectation and compare against the selected DUT.
  task automatic observe();
    exp_t       e;
    logic [3:0] nq4;
    logic [2:0] nq3;
    if (sb.size() == 0) begin
      chk("scoreboard_underflow", 32'd1, 32'd0);
      return;
    end
    e   = sb.pop_front();
    nq4 = ~e.q;
    nq3 = ~e.q[2:0];
    if (!e.sel) begin
      chk({e.name, " q"},        q_a,    e.q);
      chk({e.name, " qb"},       qb_a,   nq4);
      chk({e.name, " wrap"},     wrap_a, e.wrap);
      chk({e.name, " load_err"}, lerr_a, e.lerr);
    end else begin
      chk({e.name, " q"},        q_b,    e.q[2:0]);
      chk({e.name, " qb"},       qb_b,   nq3);
      chk({e.name, " wrap"},     wrap_b, e.wrap);
      chk({e.name, " load_err"}, lerr_b, e.lerr);
    end
  endtask

  // Drive one edge worth of inputs, check tc before the edge, results after it.
  task automatic apply(input logic sel, input logic en, input mode_t mode, input logic [3:0] d,
                       input logic exp_tc, input logic [3:0] exp_q, input logic exp_wrap,
                       input logic exp_lerr, input string name);
    exp_t e;
    @(negedge clk);
    if (!sel) begin
      en_a = en; mode_a = mode; d_a = d;
    end else begin
      en_b = en; mode_b = mode; d_b = d[2:0];
    end
    #1;
    chk({name, " tc"}, sel ? tc_b : tc_a, exp_tc);
    e.sel = sel; e.q = exp_q; e.wrap = exp_wrap; e.lerr = exp_lerr; e.name = name;
    sb.push_back(e);
    @(posedge clk);
    #1;
    observe();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_a = 1'b1; en_a = 1'b0; mode_a = MODE_HOLD; d_a = '0;
    rst_b = 1'b1; en_b = 1'b0; mode_b = MODE_HOLD; d_b = '0;
    #1;
    chk("reset q_a",    q_a,    4'd3);
    chk("reset qb_a",   qb_a,   4'hC);
    chk("reset wrap_a", wrap_a, 1'b0);
    chk("reset lerr_a", lerr_a, 1'b0);
    chk("reset q_b",    q_b,    3'd0);
    chk("reset qb_b",   qb_b,   3'd7);
    @(posedge clk);
    #1;
    chk("reset held q_a", q_a, 4'd3);
    @(negedge clk);
    rst_a = 1'b0;
    rst_b = 1'b0;

    // en, mode, d, tc(before edge), q, wrap, load_err (after edge)
    addv(1, MODE_UP,   0,  0, 4, 0, 0);
    addv(1, MODE_UP,   0,  0, 5, 0, 0);
    addv(1, MODE_UP,   0,  0, 6, 0, 0);
    addv(1, MODE_UP,   0,  0, 7, 0, 0);
    addv(1, MODE_UP,   0,  0, 8, 0, 0);
    addv(1, MODE_UP,   0,  0, 9, 0, 0);
    addv(1, MODE_UP,   0,  1, 0, 1, 0);
    addv(1, MODE_UP,   0,  0, 1, 0, 0);
    addv(1, MODE_DOWN, 0,  0, 0, 0, 0);
    addv(1, MODE_DOWN, 0,  1, 9, 1, 0);
    addv(1, MODE_LOAD, 7,  0, 7, 0, 0);
    addv(1, MODE_LOAD, 12, 0, 9, 0, 1);
    addv(1, MODE_LOAD, 9,  0, 9, 0, 0);
    for (int k = 0; k < 5; k++) addv(0, MODE_UP, 0, 0, 9, 0, 0);
    addv(0, MODE_LOAD, 15, 0, 9, 0, 0);
    addv(0, MODE_DOWN, 0,  0, 9, 0, 0);
    addv(1, MODE_HOLD, 0,  0, 9, 0, 0);
    addv(1, MODE_HOLD, 0,  0, 9, 0, 0);
    addv(1, MODE_LOAD, 15, 0, 9, 0, 1);
    addv(1, MODE_UP,   0,  1, 0, 1, 0);
    addv(1, MODE_LOAD, 10, 0, 9, 0, 1);
    addv(1, MODE_LOAD, 6,  0, 6, 0, 0);

    foreach (vecs[i]) begin
      apply(1'b0, vecs[i].en, vecs[i].mode, vecs[i].d, vecs[i].tc, vecs[i].q, vecs[i].wrap,
            vecs[i].lerr, $sformatf("vec%0d", i));
    end

    // Asynchronous reset between edges while q = 6.
    @(negedge clk);
    en_a = 1'b1; mode_a = MODE_UP;
    #2;
    rst_a = 1'b1;
    #1;
    chk("async_rst q",    q_a,    4'd3);
    chk("async_rst qb",   qb_a,   4'hC);
    chk("async_rst wrap", wrap_a, 1'b0);
    chk("async_rst lerr", lerr_a, 1'b0);
    @(posedge clk);
    #1;
    chk("async_rst hold q",    q_a,    4'd3);
    chk("async_rst hold wrap", wrap_a, 1'b0);
    @(negedge clk);
    rst_a = 1'b0;
    en_a  = 1'b0;
    apply(1'b0, 1, MODE_UP, 0, 0, 4, 0, 0, "after_rst");

    // Reset cancels a wrap pulse already in flight.
    apply(1'b0, 1, MODE_LOAD, 9, 0, 9, 0, 0, "pre_wrap");
    apply(1'b0, 1, MODE_UP,   0, 1, 0, 1, 0, "wrap_pulse");
    #2;
    rst_a = 1'b1;
    #1;
    chk("rst_kills_wrap wrap", wrap_a, 1'b0);
    chk("rst_kills_wrap q",    q_a,    4'd3);
    @(negedge clk);
    rst_a = 1'b0;
    en_a  = 1'b0;

    // Full-range 3-bit counter: natural binary wrap.
    for (int i = 0; i < 8; i++) begin
      apply(1'b1, 1, MODE_UP, 0, (i == 7), 4'((i + 1) % 8), (i == 7), 0,
            $sformatf("b_up%0d", i));
    end
    apply(1'b1, 1, MODE_DOWN, 0, 1, 7, 1, 0, "b_down_wrap");
    apply(1'b1, 1, MODE_LOAD, 5, 0, 5, 0, 0, "b_load5");
    apply(1'b1, 1, MODE_LOAD, 7, 0, 7, 0, 0, "b_load7");
    apply(1'b1, 1, MODE_UP,   0, 1, 0, 1, 0, "b_up_wrap2");

    chk("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
